// File: rtl/uart_apb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and sizes for the two-requester APB arbiter that fronts the
// UART's APB slave port.
//   arb_state_e : APB sequencing states (idle / setup / access)
//   NUM_REQ     : number of requesters (CPU adapter = 0, DMA = 1)
//   UART_ADDR_W : APB byte-address width
//   UART_DATA_W : APB data width
//   req_mask()  : converts a requester index into a one-hot requester mask
// -----------------------------------------------------------------------------
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SETUP,
    ARB_ACCESS
  } arb_state_e;

  localparam int NUM_REQ     = 2;
  localparam int UART_ADDR_W = 12;
  localparam int UART_DATA_W = 32;

  function automatic logic [NUM_REQ-1:0] req_mask(input logic idx);
    req_mask      = '0;
    req_mask[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/uart_apb_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_apb_arbiter_if
// APB link between the arbiter (master) and the UART APB slave.
//   psel_o, penable_o, pwrite_o : APB controls, driven by the master
//   paddr_o, pwdata_o           : APB address / write data, driven by the master
//   prdata_i                    : APB read data, driven by the slave
//   pready_i, pslverr_i         : APB slave response
// Signal names carry the master's point of view.
// -----------------------------------------------------------------------------
interface uart_apb_arbiter_if;
  import uart_arb_pkg::*;

  logic                   psel_o;
  logic                   penable_o;
  logic                   pwrite_o;
  logic [UART_ADDR_W-1:0] paddr_o;
  logic [UART_DATA_W-1:0] pwdata_o;
  logic [UART_DATA_W-1:0] prdata_i;
  logic                   pready_i;
  logic                   pslverr_i;

  modport master (
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
    input  prdata_i, pready_i, pslverr_i
  );

  modport slave (
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
    output prdata_i, pready_i, pslverr_i
  );

endinterface

// File: rtl/uart_rr_arb.sv
// -----------------------------------------------------------------------------
// uart_rr_arb
// Combinational two-way round-robin grant.
//   valid_i      : per-requester request vector
//   last_grant_i : index of the requester granted most recently
//   done_mask_i  : requester currently receiving its done pulse; it is not
//                  eligible this cycle, which stops immediate re-grants
//   grant_o      : one-hot grant (all zero when nothing is eligible)
// -----------------------------------------------------------------------------
module uart_rr_arb
  import uart_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               last_grant_i,
  input  logic [NUM_REQ-1:0] done_mask_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic [NUM_REQ-1:0] eligible;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    grant_o  = '0;
    eligible = valid_i & ~done_mask_i;
    if (&eligible) begin
      // Tie: the requester that did not win last time goes next.
      grant_o = last_grant_i ? 2'b01 : 2'b10;
    end else begin
      grant_o = eligible;
    end
  end

endmodule

// File: rtl/uart_apb_arbiter.sv
// -----------------------------------------------------------------------------
// uart_apb_arbiter
// Shares the UART APB slave between the CPU bus adapter (requester 0) and the
// DMA engine (requester 1). One transfer at a time, round-robin on ties, APB
// SETUP/ACCESS sequencing, and a wait-state timeout.
//   pclk_i, prst_i          : clock, asynchronous active-high reset
//   req_valid_i/write_i     : per-requester request and direction (1 = write)
//   req0/1_addr_i, _wdata_i : per-requester address and write data
//   req_done_o, req_err_o   : one-cycle completion pulse and error, per requester
//   req_rdata_o             : read data of the last completed read (shared)
//   timeout_o               : one-cycle pulse when a transfer is aborted
//   apb                     : APB master port toward the UART
// TIMEOUT_CYCLES (>= 2) is the number of ACCESS cycles allowed before abort.
// -----------------------------------------------------------------------------
module uart_apb_arbiter
  import uart_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   pclk_i,
  input  logic                   prst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ-1:0]     req_write_i,
  input  logic [UART_ADDR_W-1:0] req0_addr_i,
  input  logic [UART_ADDR_W-1:0] req1_addr_i,
  input  logic [UART_DATA_W-1:0] req0_wdata_i,
  input  logic [UART_DATA_W-1:0] req1_wdata_i,
  output logic [NUM_REQ-1:0]     req_done_o,
  output logic [NUM_REQ-1:0]     req_err_o,
  output logic [UART_DATA_W-1:0] req_rdata_o,
  output logic                   timeout_o,
  uart_apb_arbiter_if.master     apb
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e         state;
  logic               last_grant;   // also identifies the owner of the live transfer
  logic [CNT_W-1:0]   wait_cnt;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] owner_mask;

  // req_done_o is high only in the IDLE cycle that follows a completion, so it
  // doubles as the "just served" mask for arbitration.
  uart_rr_arb u_rr_arb (
    .valid_i      (req_valid_i),
    .last_grant_i (last_grant),
    .done_mask_i  (req_done_o),
    .grant_o      (grant)
  );

  assign owner_mask = req_mask(last_grant);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state         <= ARB_IDLE;
      last_grant    <= 1'b1;
      wait_cnt      <= '0;
      apb.psel_o    <= 1'b0;
      apb.penable_o <= 1'b0;
      apb.pwrite_o  <= 1'b0;
      apb.paddr_o   <= '0;
      apb.pwdata_o  <= '0;
      req_done_o    <= '0;
      req_err_o     <= '0;
      req_rdata_o   <= '0;
      timeout_o     <= 1'b0;
    end else begin
      // Completion outputs are single-cycle pulses.
      req_done_o <= '0;
      req_err_o  <= '0;
      timeout_o  <= 1'b0;

      case (state)
        ARB_IDLE: begin
          if (|grant) begin
            last_grant   <= grant[1];
            apb.pwrite_o <= grant[1] ? req_write_i[1] : req_write_i[0];
            apb.paddr_o  <= grant[1] ? req1_addr_i    : req0_addr_i;
            apb.pwdata_o <= grant[1] ? req1_wdata_i   : req0_wdata_i;
            apb.psel_o   <= 1'b1;
            wait_cnt     <= '0;
            state        <= ARB_SETUP;
          end
        end

        ARB_SETUP: begin
          apb.penable_o <= 1'b1;
          state         <= ARB_ACCESS;
        end

        ARB_ACCESS: begin
          if (apb.pready_i) begin
            req_done_o    <= owner_mask;
            req_err_o     <= apb.pslverr_i ? owner_mask : '0;
            if (!apb.pwrite_o) begin
              req_rdata_o <= apb.prdata_i;
            end
            apb.psel_o    <= 1'b0;
            apb.penable_o <= 1'b0;
            state         <= ARB_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            // Abort: report an error, leave the read data untouched.
            req_done_o    <= owner_mask;
            req_err_o     <= owner_mask;
            timeout_o     <= 1'b1;
            apb.psel_o    <= 1'b0;
            apb.penable_o <= 1'b0;
            state         <= ARB_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        default: begin
          apb.psel_o    <= 1'b0;
          apb.penable_o <= 1'b0;
          state         <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_apb_arbiter
// Directed bench for uart_apb_arbiter: a table of single transfers with
// hand-computed results, then hand-written sequences for timeout, reset in
// ACCESS and back-to-back round-robin alternation.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_apb_arbiter;
  import uart_arb_pkg::*;

  localparam int TIMEOUT_CYCLES = 16;

  logic                   pclk_i = 1'b0;
  logic                   prst_i;
  logic [NUM_REQ-1:0]     req_valid_i;
  logic [NUM_REQ-1:0]     req_write_i;
  logic [UART_ADDR_W-1:0] req0_addr_i, req1_addr_i;
  logic [UART_DATA_W-1:0] req0_wdata_i, req1_wdata_i;
  logic [NUM_REQ-1:0]     req_done_o;
  logic [NUM_REQ-1:0]     req_err_o;
  logic [UART_DATA_W-1:0] req_rdata_o;
  logic                   timeout_o;

  uart_apb_arbiter_if apb ();

  uart_apb_arbiter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .pclk_i       (pclk_i),
    .prst_i       (prst_i),
    .req_valid_i  (req_valid_i),
    .req_write_i  (req_write_i),
    .req0_addr_i  (req0_addr_i),
    .req1_addr_i  (req1_addr_i),
    .req0_wdata_i (req0_wdata_i),
    .req1_wdata_i (req1_wdata_i),
    .req_done_o   (req_done_o),
    .req_err_o    (req_err_o),
    .req_rdata_o  (req_rdata_o),
    .timeout_o    (timeout_o),
    .apb          (apb)
  );

  always #5 pclk_i = ~pclk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  write;
    logic [11:0] addr0;
    logic [11:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [31:0] prdata;
    int          waits;
    logic        slverr;
    logic [1:0]  exp_done;
    logic [1:0]  exp_err;
    logic [11:0] exp_paddr;
    logic        exp_pwrite;
    logic [31:0] exp_pwdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  // One complete transfer: request, SETUP, ACCESS (with wait states), done.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge pclk_i);
    req_valid_i   = v.valid;
    req_write_i   = v.write;
    req0_addr_i   = v.addr0;
    req1_addr_i   = v.addr1;
    req0_wdata_i  = v.wdata0;
    req1_wdata_i  = v.wdata1;
    apb.prdata_i  = v.prdata;
    apb.pslverr_i = v.slverr;
    apb.pready_i  = 1'b0;
    @(negedge pclk_i);
    check({tag, "_setup_sel_en"}, {apb.psel_o, apb.penable_o}, 2'b10);
    check({tag, "_paddr"},  apb.paddr_o,  v.exp_paddr);
    check({tag, "_pwrite"}, apb.pwrite_o, v.exp_pwrite);
    check({tag, "_pwdata"}, apb.pwdata_o, v.exp_pwdata);
    for (int c = 0; c <= v.waits; c++) begin
      @(negedge pclk_i);
      check({tag, "_access_sel_en"}, {apb.psel_o, apb.penable_o}, 2'b11);
      check({tag, "_access_no_done"}, req_done_o, 2'b00);
      apb.pready_i = (c == v.waits);
    end
    @(negedge pclk_i);
    check({tag, "_done"},    req_done_o,  v.exp_done);
    check({tag, "_err"},     req_err_o,   v.exp_err);
    check({tag, "_rdata"},   req_rdata_o, v.exp_rdata);
    check({tag, "_timeout"}, timeout_o,   1'b0);
    check({tag, "_sel_drop"}, {apb.psel_o, apb.penable_o}, 2'b00);
    req_valid_i   = 2'b00;
    apb.pready_i  = 1'b0;
    apb.pslverr_i = 1'b0;
  endtask

  initial begin
    int         acc;
    bit         seen;
    int         nd;
    logic [1:0] dn [4];
    int         dc [4];

    //            valid  write  addr0    addr1    wdata0        wdata1        prdata        w  serr  done   err    paddr    pw    pwdata        rdata
    vecs[0] = '{2'b01, 2'b01, 12'h00C, 12'h000, 32'hA5A5_0001, 32'h0,        32'h0,        0, 1'b0, 2'b01, 2'b00, 12'h00C, 1'b1, 32'hA5A5_0001, 32'h0};
    vecs[1] = '{2'b10, 2'b00, 12'h000, 12'h010, 32'h0,        32'h0,        32'h0000_0055, 3, 1'b0, 2'b10, 2'b00, 12'h010, 1'b0, 32'h0,        32'h0000_0055};
    vecs[2] = '{2'b01, 2'b00, 12'h004, 12'h000, 32'h0,        32'h0,        32'hDEAD_BEEF, 1, 1'b0, 2'b01, 2'b00, 12'h004, 1'b0, 32'h0,        32'hDEAD_BEEF};
    vecs[3] = '{2'b10, 2'b10, 12'h000, 12'h0FF, 32'h0,        32'h1234_5678, 32'h9999_9999, 0, 1'b1, 2'b10, 2'b10, 12'h0FF, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[4] = '{2'b11, 2'b01, 12'h100, 12'h200, 32'h1111_0000, 32'h0BAD_C0DE, 32'h0,      0, 1'b0, 2'b01, 2'b00, 12'h100, 1'b1, 32'h1111_0000, 32'hDEAD_BEEF};
    vecs[5] = '{2'b11, 2'b01, 12'h300, 12'h200, 32'h2222_0000, 32'h0BAD_C0DE, 32'hCAFE_F00D, 2, 1'b0, 2'b10, 2'b00, 12'h200, 1'b0, 32'h0BAD_C0DE, 32'hCAFE_F00D};
    vecs[6] = '{2'b01, 2'b00, 12'h044, 12'h000, 32'h0,        32'h0,        32'h0000_0077, 2, 1'b1, 2'b01, 2'b01, 12'h044, 1'b0, 32'h0,        32'h0000_0077};

    prst_i        = 1'b1;
    req_valid_i   = '0;
    req_write_i   = '0;
    req0_addr_i   = '0;
    req1_addr_i   = '0;
    req0_wdata_i  = '0;
    req1_wdata_i  = '0;
    apb.prdata_i  = '0;
    apb.pready_i  = 1'b0;
    apb.pslverr_i = 1'b0;

    // Reset state
    repeat (2) @(negedge pclk_i);
    prst_i = 1'b0;
    @(negedge pclk_i);
    check("rst_sel_en_wr", {apb.psel_o, apb.penable_o, apb.pwrite_o}, 3'b000);
    check("rst_paddr",  apb.paddr_o,  12'h0);
    check("rst_pwdata", apb.pwdata_o, 32'h0);
    check("rst_done_err_to", {req_done_o, req_err_o, timeout_o}, 5'b0);
    check("rst_rdata",  req_rdata_o,  32'h0);

    // Table-driven single transfers
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Timeout: pready stuck low, read data must stay at 0x77
    @(negedge pclk_i);
    req_valid_i  = 2'b01;
    req_write_i  = 2'b00;
    req0_addr_i  = 12'h020;
    apb.prdata_i = 32'hFFFF_FFFF;
    apb.pready_i = 1'b0;
    @(negedge pclk_i);
    check("to_setup_sel_en", {apb.psel_o, apb.penable_o}, 2'b10);
    acc  = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge pclk_i);
      if (apb.psel_o && apb.penable_o) acc++;
      else seen = 1'b1;
    end
    check("to_psel_dropped", seen, 1'b1);
    check("to_access_cycles", acc, TIMEOUT_CYCLES);
    check("to_done",    req_done_o,  2'b01);
    check("to_err",     req_err_o,   2'b01);
    check("to_timeout", timeout_o,   1'b1);
    check("to_rdata",   req_rdata_o, 32'h0000_0077);
    req_valid_i = 2'b00;
    @(negedge pclk_i);
    check("to_pulse_once", {req_done_o, req_err_o, timeout_o}, 5'b0);

    // Reset during the second ACCESS cycle
    @(negedge pclk_i);
    req_valid_i  = 2'b10;
    req_write_i  = 2'b10;
    req1_addr_i  = 12'h0A0;
    req1_wdata_i = 32'h5A5A_5A5A;
    apb.pready_i = 1'b0;
    repeat (3) @(negedge pclk_i);
    check("rstacc_pre_sel_en", {apb.psel_o, apb.penable_o}, 2'b11);
    #2 prst_i = 1'b1;
    #1;
    check("rstacc_async_sel_en", {apb.psel_o, apb.penable_o}, 2'b00);
    check("rstacc_no_done", req_done_o, 2'b00);
    req_valid_i = 2'b00;
    @(negedge pclk_i);
    prst_i = 1'b0;
    @(negedge pclk_i);
    check("rstacc_after_done", req_done_o, 2'b00);
    check("rstacc_after_sel", apb.psel_o, 1'b0);

    // Both requesters held valid from reset: 0,1,0,1 every 3 cycles
    req_valid_i   = 2'b11;
    req_write_i   = 2'b11;
    req0_addr_i   = 12'h001;
    req1_addr_i   = 12'h002;
    apb.pready_i  = 1'b1;
    apb.pslverr_i = 1'b0;
    nd = 0;
    for (int k = 0; k < 4; k++) begin
      dn[k] = 2'b00;
      dc[k] = 0;
    end
    for (int c = 1; c <= 30 && nd < 4; c++) begin
      @(negedge pclk_i);
      if (req_done_o != 2'b00) begin
        dn[nd] = req_done_o;
        dc[nd] = c;
        nd++;
      end
    end
    check("rr_done_count", nd, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_done%0d_who", k),   dn[k], (k % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("rr_done%0d_cycle", k), dc[k], 3 * (k + 1));
    end
    req_valid_i  = 2'b00;
    apb.pready_i = 1'b0;
    repeat (4) @(negedge pclk_i);
    check("end_idle_sel", apb.psel_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
